bakery_sched: RTL and testbench
===============================

Name: bakery_sched

Overview:
- Upstream stimulus stage for the bakery mutual-exclusion model.
- Replaces the free nondeterministic `select`/`pause` inputs with a reproducible LFSR-driven schedule, so the model can run in simulation and in bounded checks.
- A fairness override guarantees that every process index is selected within `MAXWAIT` cycles.
- The run length of consecutive `pause` assertions is bounded.

Parameters:
- `HIPROC`, 1: highest process index; indices start at 0.
- `SELMSB`, 1: MSB of `select`; `2^(SELMSB+1)` must be greater than `HIPROC`.
- `SEED`, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- `MAXWAIT`, 7: maximum number of consecutive enabled cycles a process may go unselected; range 1..15.
- `PAUSEMAX`, 3: maximum number of consecutive cycles with `pause`=1; range 1..15.

Ports:
- `clock`, input, 1: rising-edge clock shared with the bakery model.
- `reset`, input, 1: synchronous reset, active-high.
- `enable`, input, 1: advance the schedule; when low, all state is held.
- `select`, output, `SELMSB+1`: process index presented to the model; always ≤ `HIPROC`.
- `pause`, output, 1: pause/progress choice presented to the model.
- `forced`, output, 1: the current `select` came from the fairness override.
- `starved`, output, `HIPROC+1`: bitmap of processes whose age equals `MAXWAIT`.

Behaviour:
- **Registers.** All state is registered on `posedge clock`. Outputs are registers, so a computed value appears one cycle after the `enable` cycle that computed it.
- **Reset values** (when `reset`=1, taking priority over `enable`):
  - `lfsr` = `SEED` (or 1 if `SEED` is 0)
  - `select` = 0, `pause` = 0, `forced` = 0, `starved` = 0
  - all ages = 0, pause streak = 0, `rr` = 0, state = IDLE
- **LFSR.** 16-bit Fibonacci, shift left; feedback = `l[15]^l[13]^l[12]^l[10]` enters bit 0. It steps only when `enable`=1 and never reaches 0.
- **State machine.**
  - IDLE → RUN on the first `enable`.
  - RUN → FORCE when any age equals `MAXWAIT` after the update.
  - FORCE → RUN after one forced issue.
  - Any state → IDLE on `reset`.
  - With `enable`=0, state is held.
- **RUN issue (random).**
  - Candidate `c` = `lfsr_next[SELMSB:0]`.
  - If `c` > `HIPROC`, then `select` = `rr` and `rr` advances (wrapping from `HIPROC` to 0). Otherwise `select` = `c`.
  - `forced` = 0.
- **FORCE issue.** `select` = lowest index with age equal to `MAXWAIT`; `forced` = 1. If several processes are starved at once, one is served per FORCE visit, lowest index first.
- **Ages.**
  - On each enabled issue, the selected process's age is cleared to 0.
  - Every other process's age increments, saturating at `MAXWAIT`.
  - `starved[p]` = (age[p] == `MAXWAIT`), registered.
- **Pause.**
  - Raw pause = `lfsr_next[15] & lfsr_next[14]` (about 25%).
  - If the pause streak equals `PAUSEMAX`, `pause` is forced to 0 and the streak clears.
  - Otherwise `pause` = raw; the streak increments on 1 and clears on 0.
  - `pause` is independent of `forced`.
- **Widths.** Age and streak counters are 4 bits wide.
- **Reset mid-run.** Reset in any state restores the reset values on the next edge. The post-reset sequence is identical to the one after power-up reset.

Optional Feature:
- Macro `BAKERY_SCHED_FAIR_EN`.
- Defined: ages, `starved`, the FORCE state and the pause-streak limit are present as described above.
- Undefined: pure LFSR/rr issue. FORCE is unreachable, `forced` = 0, `starved` = 0, and `pause` = raw pause bit. Sequence reproducibility from `SEED` is preserved.

Decomposition:
- **Shared package `bakery_pkg`:**
  - state typedef `sched_st` {IDLE, RUN, FORCE}
  - LFSR tap constants
  - default `SEED`
  - the existing `loc` program-counter typedef, moved here so the model and its bench share it
- **One sub-module `bakery_lfsr16`:** `clock`, `reset`, `enable`, `seed` in; `lfsr` and `lfsr_next` out. Everything else stays in `bakery_sched`.

Test Plan:
- **Reset sequence:** `reset`=1 for 2 cycles, then `enable`=1 → outputs 0 during reset; the first `lfsr` after reset is 16'h59C3 (ACE1 shifted, feedback 1). With `HIPROC`=1, `select` = 1.
- **Enable hold:** `enable`=0 for 10 cycles mid-run → `select`, `pause`, `lfsr` and ages unchanged; the sequence resumes exactly where it stopped.
- **Fairness:** `HIPROC`=2, `MAXWAIT`=4, run 2000 cycles → no index unselected for more than 4 consecutive enabled cycles. Each `forced`=1 cycle selects the lowest index with `starved` set.
- **Out-of-range fold:** `HIPROC`=2, `SELMSB`=1 → every candidate of 3 yields the `rr` sequence 0, 1, 2, 0, …; `select` never equals 3.
- **Pause bound:** `PAUSEMAX`=2, run 2000 cycles → never 3 consecutive `pause`=1; at least one pause run reaches length 2.
- **Macro off:** compile without `BAKERY_SCHED_FAIR_EN` and use the same seed → `select` matches the first-scenario golden sequence until the first FORCE point; `forced` and `starved` stay 0 throughout.

Source files
------------

// File: rtl/bakery_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bakery_pkg
// Purpose  : Shared types and constants for the bakery model and its scheduler.
// Revision : 1.0
// ============================================================================
package bakery_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FORCE = 2'd2
    } sched_st;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] c_LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] c_DEFAULT_SEED = 16'hACE1;

    // Program counter of one bakery process.
    typedef enum logic [2:0] {
        L_NCS      = 3'd0,
        L_CHOOSE   = 3'd1,
        L_MAXNUM   = 3'd2,
        L_SETNUM   = 3'd3,
        L_WAITCH   = 3'd4,
        L_WAITNUM  = 3'd5,
        L_CRIT     = 3'd6,
        L_EXIT     = 3'd7
    } loc;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], ^(l & c_LFSR_TAPS)};
    endfunction

endpackage : bakery_pkg
`default_nettype wire

// File: rtl/bakery_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : bakery_lfsr16
// Purpose  : 16-bit Fibonacci LFSR (shift left) with enable and non-zero seed.
// Revision : 1.0
// ============================================================================
module bakery_lfsr16
    import bakery_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] lfsr,
    output logic [15:0] lfsr_next
);

    logic [15:0] r_lfsr;
    logic [15:0] w_seed_safe;

    // An all-zero state would lock the register, so a zero seed becomes 1.
    assign w_seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
    assign lfsr_next   = lfsr_step(r_lfsr);
    assign lfsr        = r_lfsr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= w_seed_safe;
        end else if (enable) begin
            r_lfsr <= lfsr_next;
        end
    end

endmodule : bakery_lfsr16
`default_nettype wire

// File: rtl/bakery_sched.sv
`default_nettype none
// ============================================================================
// Module   : bakery_sched
// Purpose  : LFSR-driven select/pause schedule for the bakery model.
//            BAKERY_SCHED_FAIR_EN adds ageing, forced issue and a pause-run limit.
// Revision : 1.0
// ============================================================================
module bakery_sched
    import bakery_pkg::*;
#(
    parameter int          HIPROC   = 1,
    parameter int          SELMSB   = 1,
    parameter logic [15:0] SEED     = c_DEFAULT_SEED,
    parameter int          MAXWAIT  = 7,
    parameter int          PAUSEMAX = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    output logic [SELMSB:0] select,
    output logic            pause,
    output logic            forced,
    output logic [HIPROC:0] starved
);

    localparam logic [SELMSB:0] c_HI_SEL = HIPROC[SELMSB:0];
    localparam logic [3:0]      c_MAXW   = MAXWAIT[3:0];
    localparam logic [3:0]      c_PMAX   = PAUSEMAX[3:0];

    logic [15:0]     w_lfsr;
    logic [15:0]     w_lfsr_next;
    logic [SELMSB:0] w_cand;
    logic            w_raw_pause;

    sched_st         r_state;
    sched_st         w_state_next;
    logic [SELMSB:0] r_rr;
    logic [SELMSB:0] w_rr_next;
    logic [SELMSB:0] r_select;
    logic [SELMSB:0] w_issue_sel;
    logic            r_pause;
    logic            w_pause_next;
    logic            r_forced;
    logic            w_issue_forced;
    logic            w_force_now;
    logic [SELMSB:0] w_force_idx;
    logic [HIPROC:0] w_starved_next;
    logic            w_unused;

    bakery_lfsr16 u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed      (SEED),
        .lfsr      (w_lfsr),
        .lfsr_next (w_lfsr_next)
    );

    assign w_cand      = w_lfsr_next[SELMSB:0];
    assign w_raw_pause = w_lfsr_next[15] & w_lfsr_next[14];
    assign w_unused    = ^{w_lfsr, w_lfsr_next, c_MAXW, c_PMAX};

`ifdef BAKERY_SCHED_FAIR_EN
    logic [3:0]      r_age [HIPROC+1];
    logic [3:0]      w_age_next [HIPROC+1];
    logic [3:0]      r_streak;
    logic [3:0]      w_streak_next;
    logic [HIPROC:0] r_starved;

    assign w_force_now = (r_state == FORCE);
    assign starved     = r_starved;

    // Descending scan so the lowest starved index is the one left standing.
    always_comb begin
        w_force_idx = '0;
        for (int p = HIPROC; p >= 0; p--) begin
            if (r_age[p] == c_MAXW) begin
                w_force_idx = p[SELMSB:0];
            end
        end
    end

    always_comb begin
        w_starved_next = '0;
        for (int p = 0; p <= HIPROC; p++) begin
            if (w_issue_sel == p[SELMSB:0]) begin
                w_age_next[p] = 4'd0;
            end else if (r_age[p] == c_MAXW) begin
                w_age_next[p] = r_age[p];
            end else begin
                w_age_next[p] = r_age[p] + 4'd1;
            end
            w_starved_next[p] = (w_age_next[p] == c_MAXW);
        end
    end

    always_comb begin
        w_pause_next  = w_raw_pause;
        w_streak_next = w_raw_pause ? (r_streak + 4'd1) : 4'd0;
        if (r_streak == c_PMAX) begin
            w_pause_next  = 1'b0;
            w_streak_next = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int p = 0; p <= HIPROC; p++) begin
                r_age[p] <= 4'd0;
            end
            r_streak  <= 4'd0;
            r_starved <= '0;
        end else if (enable) begin
            for (int p = 0; p <= HIPROC; p++) begin
                r_age[p] <= w_age_next[p];
            end
            r_streak  <= w_streak_next;
            r_starved <= w_starved_next;
        end
    end
`else
    assign w_force_now    = 1'b0;
    assign w_force_idx    = '0;
    assign w_starved_next = '0;
    assign w_pause_next   = w_raw_pause;
    assign starved        = '0;
`endif

    // Out-of-range candidates fall back to the round-robin pointer.
    always_comb begin
        w_rr_next      = r_rr;
        w_issue_forced = 1'b0;
        if (w_cand > c_HI_SEL) begin
            w_issue_sel = r_rr;
            w_rr_next   = (r_rr == c_HI_SEL) ? '0 : (r_rr + 1'b1);
        end else begin
            w_issue_sel = w_cand;
        end
        if (w_force_now) begin
            w_issue_sel    = w_force_idx;
            w_issue_forced = 1'b1;
            w_rr_next      = r_rr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, RUN: w_state_next = (|w_starved_next) ? FORCE : RUN;
            FORCE:     w_state_next = RUN;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rr     <= '0;
            r_select <= '0;
            r_pause  <= 1'b0;
            r_forced <= 1'b0;
        end else if (enable) begin
            r_state  <= w_state_next;
            r_rr     <= w_rr_next;
            r_select <= w_issue_sel;
            r_pause  <= w_pause_next;
            r_forced <= w_issue_forced;
        end
    end

    assign select = r_select;
    assign pause  = r_pause;
    assign forced = r_forced;

endmodule : bakery_sched
`default_nettype wire

// File: tb/tb_bakery_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bakery_sched
// Purpose  : Directed self-checking bench for bakery_sched (two configurations).
// Revision : 1.0
// ============================================================================
module tb_bakery_sched;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;

    logic       sel_a;
    logic       pause_a;
    logic       forced_a;
    logic [1:0] starved_a;
    logic [1:0] sel_b;
    logic       pause_b;
    logic       forced_b;
    logic [2:0] starved_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    bakery_sched #(.HIPROC(1), .SELMSB(0), .SEED(16'hACE1), .MAXWAIT(7), .PAUSEMAX(3)) dut_a (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .select  (sel_a),
        .pause   (pause_a),
        .forced  (forced_a),
        .starved (starved_a)
    );

    bakery_sched #(.HIPROC(2), .SELMSB(1), .SEED(16'hACE1), .MAXWAIT(4), .PAUSEMAX(2)) dut_b (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .select  (sel_b),
        .pause   (pause_b),
        .forced  (forced_b),
        .starved (starved_b)
    );

    typedef struct packed {
        logic [15:0]     lfsr;
        int              rr;
        int              streak;
        int              sel;
        logic [3:0][3:0] age;
        logic            fpend;
        logic            pse;
        logic            frc;
        logic [3:0]      stv;
    } mst_t;

    function automatic mst_t model_reset();
        mst_t r = '0;
        r.lfsr = 16'hACE1;
        return r;
    endfunction

    function automatic mst_t model_step(mst_t s, int hi, int smsb, int mw, int pm);
        mst_t        n = s;
        logic [15:0] ln;
        int          c;
        logic        raw;
        logic        any;
        ln  = {s.lfsr[14:0], s.lfsr[15] ^ s.lfsr[13] ^ s.lfsr[12] ^ s.lfsr[10]};
        c   = int'(ln) % (1 << (smsb + 1));
        raw = ln[15] & ln[14];
        n.lfsr = ln;
        n.frc  = 1'b0;
        if (c > hi) begin
            n.sel = s.rr;
            n.rr  = (s.rr == hi) ? 0 : s.rr + 1;
        end else begin
            n.sel = c;
        end
        n.pse = raw;
        n.stv = '0;
`ifdef BAKERY_SCHED_FAIR_EN
        if (s.fpend) begin
            bit found = 1'b0;
            n.rr  = s.rr;
            n.frc = 1'b1;
            for (int q = 0; q <= hi; q++) begin
                if (!found && int'(s.age[q]) == mw) begin
                    n.sel = q;
                    found = 1'b1;
                end
            end
        end
        any = 1'b0;
        for (int q = 0; q <= hi; q++) begin
            if (q == n.sel) n.age[q] = 4'd0;
            else if (int'(s.age[q]) < mw) n.age[q] = s.age[q] + 4'd1;
            n.stv[q] = (int'(n.age[q]) == mw);
            any = any | n.stv[q];
        end
        n.fpend = !s.fpend && any;
        if (s.streak == pm) begin
            n.pse    = 1'b0;
            n.streak = 0;
        end else begin
            n.streak = raw ? s.streak + 1 : 0;
        end
`else
        any = 1'b0;
        n.fpend = any;
`endif
        return n;
    endfunction

    function automatic int lowest_bit(logic [2:0] v);
        for (int q = 0; q < 3; q++) if (v[q]) return q;
        return 7;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_vec(input string tag, input int sa, input int sb, input int pa, input int lf);
        chk({tag, "/a_sel"},     int'(sel_a), sa);
        chk({tag, "/b_sel"},     int'(sel_b), sb);
        chk({tag, "/a_pause"},   int'(pause_a), pa);
        chk({tag, "/b_pause"},   int'(pause_b), pa);
        chk({tag, "/a_lfsr"},    int'(dut_a.u_lfsr.lfsr), lf);
        chk({tag, "/b_lfsr"},    int'(dut_b.u_lfsr.lfsr), lf);
        chk({tag, "/a_forced"},  int'(forced_a), 0);
        chk({tag, "/b_forced"},  int'(forced_b), 0);
        chk({tag, "/a_starved"}, int'(starved_a), 0);
        chk({tag, "/b_starved"}, int'(starved_b), 0);
    endtask

    // Hand-derived: ACE1 -> 59C3 -> B387 -> 670F -> CE1E -> 9C3C -> 3879 -> 70F2.
    int exp_lf [6] = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E, 16'h9C3C, 16'h3879};
    int exp_sa [6] = '{1, 1, 1, 0, 0, 1};
    int exp_sb [6] = '{0, 1, 2, 2, 0, 1};
    int exp_pa [6] = '{0, 0, 0, 1, 0, 0};

    initial begin
        mst_t       ma;
        mst_t       mb;
        int         run_a = 0;
        int         run_b = 0;
        int         max_run_a = 0;
        int         max_run_b = 0;
        int         wait_a [2] = '{0, 0};
        int         max_wait_a = 0;
        logic [2:0] prev_stv_b;

        // Reset held two cycles with enable low.
        cyc();
        cyc();
        chk_vec("reset", 0, 0, 0, 16'hACE1);

        reset  = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_vec($sformatf("seq%0d", k), exp_sa[k], exp_sb[k], exp_pa[k], exp_lf[k]);
        end

        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_vec("hold", 1, 1, 0, 16'h3879);
        end

        enable = 1'b1;
        cyc();
        chk_vec("resume", 0, 2, 0, 16'h70F2);

        // Reset wins over enable, and the sequence restarts from the seed.
        reset = 1'b1;
        cyc();
        chk_vec("midreset", 0, 0, 0, 16'hACE1);
        reset = 1'b0;
        cyc();
        chk_vec("restart", 1, 0, 0, 16'h59C3);

        ma = model_step(model_reset(), 1, 0, 7, 3);
        mb = model_step(model_reset(), 2, 1, 4, 2);
        prev_stv_b = starved_b;

        for (int i = 0; i < 2000; i++) begin
            enable = ((i % 97) != 96);
            cyc();
            if (enable) begin
                ma = model_step(ma, 1, 0, 7, 3);
                mb = model_step(mb, 2, 1, 4, 2);
                run_a = pause_a ? run_a + 1 : 0;
                run_b = pause_b ? run_b + 1 : 0;
                if (run_a > max_run_a) max_run_a = run_a;
                if (run_b > max_run_b) max_run_b = run_b;
                for (int p = 0; p < 2; p++) begin
                    wait_a[p] = (int'(sel_a) == p) ? 0 : wait_a[p] + 1;
                    if (wait_a[p] > max_wait_a) max_wait_a = wait_a[p];
                end
`ifdef BAKERY_SCHED_FAIR_EN
                if (forced_b) chk("b_force_lowest", int'(sel_b), lowest_bit(prev_stv_b));
`endif
                prev_stv_b = starved_b;
            end
            chk("run/a_sel",     int'(sel_a),     ma.sel);
            chk("run/a_pause",   int'(pause_a),   int'(ma.pse));
            chk("run/a_forced",  int'(forced_a),  int'(ma.frc));
            chk("run/a_starved", int'(starved_a), int'(ma.stv[1:0]));
            chk("run/b_sel",     int'(sel_b),     mb.sel);
            chk("run/b_pause",   int'(pause_b),   int'(mb.pse));
            chk("run/b_forced",  int'(forced_b),  int'(mb.frc));
            chk("run/b_starved", int'(starved_b), int'(mb.stv[2:0]));
            chk("run/b_sel_range", int'(sel_b <= 2'd2), 1);
        end

`ifdef BAKERY_SCHED_FAIR_EN
        chk("b_pause_maxrun", max_run_b, 2);
        chk("a_pause_maxrun_le3", int'(max_run_a <= 3), 1);
        chk("a_maxwait_le7", int'(max_wait_a <= 7), 1);
`else
        chk("b_pause_run_ge2", int'(max_run_b >= 2), 1);
        chk("a_wait_seen", int'(max_wait_a >= 1), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bakery_sched
`default_nettype wire
